// File: rtl/multi_gate_lion_counter.sv
// multi_gate_lion_counter
// Counts lions in a cage that has NUM_GATES doors. Each door has an outer and
// an inner light gate. A complete outer->inner->clear crossing is one entry
// and inner->outer->clear is one exit. Every door runs its own tracking FSM,
// and all events committed in a cycle are summed into one saturating count.
//
// Optional feature: define LION_DEBOUNCE_EN to add a per-beam stability
// filter. A beam's filtered value changes only after DEB_CYCLES consecutive
// identical synchronised samples.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   gate_outer   per-door outer beam broken (asynchronous input)
//   gate_inner   per-door inner beam broken (asynchronous input)
//   clr          synchronous clear of lion_count and fault
//   lion_count   registered occupancy
//   cage_full    lion_count == MAX_LIONS (decoded from the register)
//   cage_empty   lion_count == 0 (decoded from the register)
//   enter_pulse  one cycle: the count went up
//   exit_pulse   one cycle: the count went down
//   fault        sticky: a result had to be clamped to 0 or MAX_LIONS
module multi_gate_lion_counter #(
    parameter int unsigned NUM_GATES  = 2,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned MAX_LIONS  = 15,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_GATES-1:0] gate_outer,
    input  logic [NUM_GATES-1:0] gate_inner,
    input  logic                 clr,
    output logic [CNT_W-1:0]     lion_count,
    output logic                 cage_full,
    output logic                 cage_empty,
    output logic                 enter_pulse,
    output logic                 exit_pulse,
    output logic                 fault
);

    // Signed working width: room for the count plus up to 8 simultaneous events.
    localparam int unsigned SUM_W = CNT_W + 5;
    localparam int unsigned NB    = 2 * NUM_GATES;
    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_LIONS);

    // Elaboration-time parameter sanity checks
    if (NUM_GATES < 1 || NUM_GATES > 8) begin : g_bad_gates
        $error("NUM_GATES out of range");
    end
    if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
        $error("CNT_W out of range");
    end
    if (MAX_LIONS > (2 ** CNT_W) - 1) begin : g_bad_max
        $error("MAX_LIONS does not fit in CNT_W");
    end
    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_E1, S_E2, S_E3, S_X1, S_X2, S_X3
    } door_state_e;

    // Two-flop synchronisers; beams packed as {inner, outer}
    logic [NB-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {gate_inner, gate_outer};
            sync2_q <= sync1_q;
        end
    end

    logic [NB-1:0] beam_c;

`ifdef LION_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [NB-1:0]    filt_q, filt_d;
    logic [DEB_W-1:0] deb_cnt_q [NB];
    logic [DEB_W-1:0] deb_cnt_d [NB];

    // The counter tracks how long the sample has disagreed with the filtered value
    always_comb begin
        filt_d = filt_q;
        for (int b = 0; b < int'(NB); b++) begin
            deb_cnt_d[b] = '0;
            if (sync2_q[b] != filt_q[b]) begin
                if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    filt_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int b = 0; b < int'(NB); b++) begin
                deb_cnt_q[b] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int b = 0; b < int'(NB); b++) begin
                deb_cnt_q[b] <= deb_cnt_d[b];
            end
        end
    end

    assign beam_c = filt_q;
`else
    assign beam_c = sync2_q;
`endif

    // Door tracking FSM transition, oi = {outer, inner}
    function automatic door_state_e door_next(input door_state_e st, input logic [1:0] oi);
        door_state_e nx;
        nx = st;
        case (st)
            S_IDLE: begin
                if (oi == 2'b10)      nx = S_E1;
                else if (oi == 2'b01) nx = S_X1;
            end
            S_E1: begin
                case (oi)
                    2'b11:   nx = S_E2;
                    2'b00:   nx = S_IDLE;
                    2'b01:   nx = S_E3;
                    default: nx = S_E1;
                endcase
            end
            S_E2: begin
                case (oi)
                    2'b01:   nx = S_E3;
                    2'b10:   nx = S_E1;
                    2'b00:   nx = S_IDLE;
                    default: nx = S_E2;
                endcase
            end
            S_E3: begin
                case (oi)
                    2'b00:   nx = S_IDLE;
                    2'b11:   nx = S_E2;
                    2'b10:   nx = S_E1;
                    default: nx = S_E3;
                endcase
            end
            S_X1: begin
                case (oi)
                    2'b11:   nx = S_X2;
                    2'b00:   nx = S_IDLE;
                    2'b10:   nx = S_X3;
                    default: nx = S_X1;
                endcase
            end
            S_X2: begin
                case (oi)
                    2'b10:   nx = S_X3;
                    2'b01:   nx = S_X1;
                    2'b00:   nx = S_IDLE;
                    default: nx = S_X2;
                endcase
            end
            S_X3: begin
                case (oi)
                    2'b00:   nx = S_IDLE;
                    2'b11:   nx = S_X2;
                    2'b01:   nx = S_X1;
                    default: nx = S_X3;
                endcase
            end
            default: nx = S_IDLE;
        endcase
        return nx;
    endfunction

    door_state_e          state_q [NUM_GATES];
    door_state_e          state_d [NUM_GATES];
    logic [NUM_GATES-1:0] ent_c, ext_c;

    // Per-door next state; an event fires on the final step back to IDLE
    always_comb begin
        for (int g = 0; g < int'(NUM_GATES); g++) begin
            state_d[g] = door_next(state_q[g], {beam_c[g], beam_c[NUM_GATES + g]});
            ent_c[g]   = (state_q[g] == S_E3) && (beam_c[g] == 1'b0) && (beam_c[NUM_GATES + g] == 1'b0);
            ext_c[g]   = (state_q[g] == S_X3) && (beam_c[g] == 1'b0) && (beam_c[NUM_GATES + g] == 1'b0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < int'(NUM_GATES); g++) begin
                state_q[g] <= S_IDLE;
            end
        end else begin
            for (int g = 0; g < int'(NUM_GATES); g++) begin
                state_q[g] <= state_d[g];
            end
        end
    end

    logic [CNT_W-1:0]        lion_count_q, lion_count_d;
    logic                    fault_q, fault_d;
    logic                    enter_pulse_q, enter_pulse_d;
    logic                    exit_pulse_q, exit_pulse_d;
    logic [SUM_W-1:0]        n_ent_c, n_ext_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0]        clamp_c;
    logic                    sat_c;

    // Net change across all doors, clamped to [0, MAX_LIONS] without wrapping
    always_comb begin
        n_ent_c = '0;
        n_ext_c = '0;
        for (int g = 0; g < int'(NUM_GATES); g++) begin
            n_ent_c = n_ent_c + SUM_W'(ent_c[g]);
            n_ext_c = n_ext_c + SUM_W'(ext_c[g]);
        end
        sum_c = $signed(SUM_W'(lion_count_q)) + $signed(n_ent_c) - $signed(n_ext_c);

        sat_c   = 1'b0;
        clamp_c = sum_c[CNT_W-1:0];
        if (sum_c[SUM_W-1]) begin
            sat_c   = 1'b1;
            clamp_c = '0;
        end else if (sum_c > MAX_S) begin
            sat_c   = 1'b1;
            clamp_c = CNT_W'(MAX_LIONS);
        end

        lion_count_d  = clamp_c;
        fault_d       = fault_q | sat_c;
        enter_pulse_d = (clamp_c > lion_count_q);
        exit_pulse_d  = (clamp_c < lion_count_q);
        if (clr) begin
            lion_count_d  = '0;
            fault_d       = 1'b0;
            enter_pulse_d = 1'b0;
            exit_pulse_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lion_count_q  <= '0;
            fault_q       <= 1'b0;
            enter_pulse_q <= 1'b0;
            exit_pulse_q  <= 1'b0;
        end else begin
            lion_count_q  <= lion_count_d;
            fault_q       <= fault_d;
            enter_pulse_q <= enter_pulse_d;
            exit_pulse_q  <= exit_pulse_d;
        end
    end

    assign lion_count  = lion_count_q;
    assign fault       = fault_q;
    assign enter_pulse = enter_pulse_q;
    assign exit_pulse  = exit_pulse_q;
    assign cage_full   = (lion_count_q == CNT_W'(MAX_LIONS));
    assign cage_empty  = (lion_count_q == '0);

endmodule

// File: tb/tb_multi_gate_lion_counter.sv
// Scoreboard bench for multi_gate_lion_counter: directed crossings, saturation,
// clear, reset mid-transit, then a randomised walk of beam patterns.
module tb_multi_gate_lion_counter;

    localparam int unsigned NG   = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned MAXL = 15;
    localparam int unsigned DEB  = 4;
`ifdef LION_DEBOUNCE_EN
    localparam int LAT      = 3 + DEB;
    localparam int MIN_HOLD = DEB;
`else
    localparam int LAT      = 3;
    localparam int MIN_HOLD = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NG-1:0] gate_outer = '0;
    logic [NG-1:0] gate_inner = '0;
    logic          clr = 1'b0;
    logic [CW-1:0] lion_count;
    logic          cage_full, cage_empty, enter_pulse, exit_pulse, fault;

    multi_gate_lion_counter #(
        .NUM_GATES (NG),
        .CNT_W     (CW),
        .MAX_LIONS (MAXL),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gate_outer (gate_outer),
        .gate_inner (gate_inner),
        .clr        (clr),
        .lion_count (lion_count),
        .cage_full  (cage_full),
        .cage_empty (cage_empty),
        .enter_pulse(enter_pulse),
        .exit_pulse (exit_pulse),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit enter;
        bit leave;
        bit flt;
    } exp_t;

    exp_t sb[$];
    bit   clr_dly[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference: a door remembers the direction it was first entered from
    // (outer-only = entering, inner-only = leaving) and the last non-clear
    // pattern; a crossing counts when all beams clear right after the far beam
    // was the only one broken.
    int       m_count;
    bit       m_fault;
    int       m_dir  [NG];   // 0 none, 1 entering, 2 leaving
    bit [1:0] m_last [NG];

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_fault = 0;
        for (int g = 0; g < int'(NG); g++) begin
            m_dir[g]  = 0;
            m_last[g] = 2'b00;
        end
        clr_dly.delete();
        for (int k = 0; k < LAT - 1; k++) clr_dly.push_back(1'b0);
    endtask

    task automatic model_cycle(input logic [NG-1:0] o, input logic [NG-1:0] i, input bit c);
        int   ent = 0;
        int   ext = 0;
        int   raw, nw;
        exp_t e;
        for (int g = 0; g < int'(NG); g++) begin
            bit [1:0] p;
            p = {o[g], i[g]};
            if (p == 2'b00) begin
                if (m_dir[g] == 1 && m_last[g] == 2'b01) ent++;
                if (m_dir[g] == 2 && m_last[g] == 2'b10) ext++;
                m_dir[g] = 0;
            end else if (m_dir[g] == 0) begin
                if (p == 2'b10) m_dir[g] = 1;
                else if (p == 2'b01) m_dir[g] = 2;
            end
            m_last[g] = p;
        end
        e.enter = 0;
        e.leave = 0;
        if (c) begin
            m_count = 0;
            m_fault = 0;
        end else begin
            raw = m_count + ent - ext;
            nw  = (raw < 0) ? 0 : ((raw > int'(MAXL)) ? int'(MAXL) : raw);
            if (nw != raw) m_fault = 1;
            e.enter = (nw > m_count);
            e.leave = (nw < m_count);
            m_count = nw;
        end
        e.count = m_count;
        e.flt   = m_fault;
        sb.push_back(e);
    endtask

    // Drive one cycle; mo/mi is what the model sees (differs only for glitches).
    // clr is delayed so it lands on the same edge as the events of this cycle.
    task automatic step_m(input logic [NG-1:0] o, input logic [NG-1:0] i,
                          input logic [NG-1:0] mo, input logic [NG-1:0] mi, input bit c);
        @(negedge clk);
        gate_outer = o;
        gate_inner = i;
        clr_dly.push_back(c);
        clr = clr_dly.pop_front();
        model_cycle(mo, mi, c);
    endtask

    task automatic step(input logic [NG-1:0] o, input logic [NG-1:0] i, input bit c);
        step_m(o, i, o, i, c);
    endtask

    // Four phases of {outer,inner} per door, each held 8 clocks
    task automatic run_seq(input logic [7:0] s0, input logic [7:0] s1);
        for (int k = 0; k < 4; k++) begin
            logic [NG-1:0] o, i;
            o = {s1[7-2*k], s0[7-2*k]};
            i = {s1[6-2*k], s0[6-2*k]};
            repeat (8) step(o, i, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_count"}, int'(lion_count), 0);
        chk({tag, "_empty"}, int'(cage_empty), 1);
        chk({tag, "_full"},  int'(cage_full), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_pulses"}, int'({enter_pulse, exit_pulse}), 0);
    endtask

    // Reset is applied asynchronously mid-cycle with the beams cleared
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        gate_outer = '0;
        gate_inner = '0;
        clr = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_reset_outputs("async_reset");
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expected record per cycle once the pipeline has filled
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() >= LAT) begin
                e = sb.pop_front();
                chk("lion_count",  int'(lion_count),  e.count);
                chk("enter_pulse", int'(enter_pulse), int'(e.enter));
                chk("exit_pulse",  int'(exit_pulse),  int'(e.leave));
                chk("fault",       int'(fault),       int'(e.flt));
                chk("cage_full",   int'(cage_full),   int'(e.count == int'(MAXL)));
                chk("cage_empty",  int'(cage_empty),  int'(e.count == 0));
            end
        end
    end

    localparam logic [7:0] ENTRY = 8'b10_11_01_00;
    localparam logic [7:0] EXIT  = 8'b01_11_10_00;
    localparam logic [7:0] BACK  = 8'b10_11_10_00;
    localparam logic [7:0] NONE  = 8'b00_00_00_00;

    initial begin
        int            hold [NG];
        logic [NG-1:0] ro, ri;

        model_reset();
        #1;
        check_reset_outputs("power_on");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_seq(ENTRY, NONE);            // 0 -> 1
        run_seq(ENTRY, ENTRY);           // 1 -> 3, two simultaneous entries
        run_seq(NONE, EXIT);             // 3 -> 2
        run_seq(BACK, NONE);             // backs out, stays 2
        for (int k = 0; k < 6; k++) run_seq(ENTRY, ENTRY);   // 2 -> 14
        run_seq(NONE, ENTRY);            // 14 -> 15
        run_seq(ENTRY, ENTRY);           // clamp at 15, fault
        repeat (4) step('0, '0, 1'b1);   // clear
        repeat (4) step('0, '0, 1'b0);
        run_seq(ENTRY, ENTRY);
        run_seq(ENTRY, ENTRY);
        run_seq(ENTRY, NONE);            // count 5
        run_seq(ENTRY, EXIT);            // simultaneous entry+exit, stays 5
        run_seq(NONE, EXIT);
        run_seq(NONE, EXIT);
        run_seq(NONE, EXIT);
        run_seq(NONE, EXIT);
        run_seq(NONE, EXIT);
        run_seq(NONE, EXIT);             // exit at 0: clamp, fault

        // Door 0 reaches E2, then reset; finishing the path must not count
        repeat (8) step(2'b01, 2'b00, 1'b0);
        repeat (8) step(2'b01, 2'b01, 1'b0);
        do_reset(3);
        repeat (8) step(2'b00, 2'b01, 1'b0);
        repeat (8) step(2'b00, 2'b00, 1'b0);

`ifdef LION_DEBOUNCE_EN
        // Two-cycle glitches on outer beams are filtered out entirely
        for (int k = 0; k < 4; k++) begin
            repeat (2) step_m(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
            repeat (6) step(2'b00, 2'b00, 1'b0);
        end
        run_seq(ENTRY, NONE);
`endif

        // Random walk of beam patterns with independent per-door hold times
        for (int g = 0; g < int'(NG); g++) hold[g] = 0;
        ro = '0;
        ri = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int g = 0; g < int'(NG); g++) begin
                if (hold[g] == 0) begin
                    logic [1:0] p;
                    p       = 2'($urandom_range(0, 3));
                    ro[g]   = p[1];
                    ri[g]   = p[0];
                    hold[g] = int'($urandom_range(MIN_HOLD, MIN_HOLD + 5));
                end
                hold[g]--;
            end
            step(ro, ri, ($urandom_range(0, 99) == 0));
        end
        repeat (16) step('0, '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_gate_lion_counter.md
MULTI_GATE_LION_COUNTER -- requirements
Module: multi_gate_lion_counter

Interface
REQ-001 Parameter: NUM_GATES, 2, number of independent cage doors, each with one outer/inner light-gate pair (1..8).
REQ-002 Parameter: CNT_W, 4, width of occupancy counter (2..8).
REQ-003 Parameter: MAX_LIONS, 15, cage capacity; SHALL satisfy MAX_LIONS <= 2^CNT_W-1.
REQ-004 Parameter: DEB_CYCLES, 4, debounce stability window in clocks (>=1), used only when LION_DEBOUNCE_EN is defined.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 gate_outer  input  NUM_GATES  per door, 1 = outer beam broken; asynchronous to clk.
REQ-008 gate_inner  input  NUM_GATES  per door, 1 = inner beam broken; asynchronous to clk.
REQ-009 clr  input  1  synchronous clear of lion_count and fault.
REQ-010 lion_count  output  CNT_W  current occupancy, registered.
REQ-011 cage_full  output  1  high when lion_count == MAX_LIONS.
REQ-012 cage_empty  output  1  high when lion_count == 0.
REQ-013 enter_pulse  output  1  one-cycle pulse when net count increases.
REQ-014 exit_pulse  output  1  one-cycle pulse when net count decreases.
REQ-015 fault  output  1  sticky flag: saturation clamp occurred.

Function
REQ-016 Each gate input SHALL pass a 2-flop synchroniser before use; filtered value O/I per door.
REQ-017 Each door SHALL run an independent 7-state FSM: IDLE, E1, E2, E3 (entry path), X1, X2, X3 (exit path).
REQ-018 IDLE: O&!I -> E1; !O&I -> X1; O&I or !O&!I -> stay IDLE, no event.
REQ-019 E1: O&I -> E2; !O&!I -> IDLE (abort); !O&I -> E3; else stay.  X1 mirrored: O&I -> X2; !O&!I -> IDLE; O&!I -> X3.
REQ-020 E2: !O&I -> E3; O&!I -> E1; !O&!I -> IDLE (abort).  X2 mirrored: O&!I -> X3; !O&I -> X1; !O&!I -> IDLE.
REQ-021 E3: !O&!I -> IDLE with one entry event; O&I -> E2; O&!I -> E1.  X3: !O&!I -> IDLE with one exit event; O&I -> X2; !O&I -> X1.
REQ-022 Per cycle, net = (sum of entry events) - (sum of exit events) across all doors; simultaneous events on different doors SHALL all be counted.
REQ-023 lion_count_next = clamp(lion_count + net, 0, MAX_LIONS), computed at width >= CNT_W+4 with sign; no wrap-around.
REQ-024 If the unclamped result is <0 or >MAX_LIONS, fault SHALL set and remain set until clr or reset.
REQ-025 lion_count, enter_pulse, exit_pulse SHALL update on the same edge the FSM commits the event; pulses reflect sign of the clamped change (net=0 or clamped-to-no-change: no pulse).
REQ-026 Latency (debounce off): beam change on input to FSM reaction = 3 rising edges; count update on that same edge.
REQ-027 clr SHALL zero lion_count and fault next edge; clr has priority over same-cycle events; door FSMs unaffected.
REQ-028 cage_full/cage_empty SHALL be combinational decodes of registered lion_count.

Reset
REQ-029 rst_n low SHALL immediately clear: synchronisers, debounce state, all FSMs to IDLE, lion_count=0, fault=0, pulses=0; cage_empty=1, cage_full=0.
REQ-030 Reset mid-transit SHALL discard the partial crossing; no event after release.
REQ-031 Reset release SHALL be used synchronously (deassertion sampled at clk).

Configuration
REQ-032 Macro LION_DEBOUNCE_EN defined: each synchronised beam SHALL update its filtered value only after DEB_CYCLES consecutive identical samples; latency grows by DEB_CYCLES.
REQ-033 Macro undefined: filtered value = synchroniser output; no debounce logic, DEB_CYCLES ignored.

Verification
REQ-034 Door 0 sequence O, O+I, I, clear (each held 8 clocks) -> lion_count 0->1, one enter_pulse, fault=0.
REQ-035 Door 1 reverse sequence I, O+I, O, clear at count 3 -> count 2, one exit_pulse.
REQ-036 Door 0 O, O+I, O, clear (backs out) -> count unchanged, no pulse.
REQ-037 Count 15 (MAX_LIONS=15), doors 0 and 1 both complete entry same cycle -> count stays 15, fault=1, no enter_pulse; clr -> count 0, fault 0.
REQ-038 Count 5, door 0 entry and door 1 exit commit same cycle -> count 5, no pulses; rst_n low during E2 -> count 0, FSM IDLE, no event after release.
REQ-039 With LION_DEBOUNCE_EN, DEB_CYCLES=4: 2-cycle glitches on gate_outer -> no state change; clean entry -> count +1.
